vc_fifo_bank: RTL

VC_FIFO_BANK -- requirements
Module: vc_fifo_bank

---
 rtl/vc_fifo_bank.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: NUM_VC independent circular FIFOs sharing one write port and
// one read port. Each channel reports occupancy, full/empty, programmable
// almost-full/almost-empty, a sticky error bit and a registered head-of-queue
// word. Reads have one cycle of latency.
//
// Ports
//   clk                 rising-edge clock
//   reset, init         active-low, synchronous; either one clears the bank
//   wr_enable/wr_vc/data_in   write request, target channel, data
//   rd_enable/rd_vc           read request, source channel
//   umbral_af/umbral_ae       packed per-channel thresholds (ADDR_WIDTH each)
//   full/empty/almost_full/almost_empty/error   one bit per channel
//   data_out/valid_out        read data, qualified one cycle after the read
//   data_peek                 packed head-of-queue word per channel
//   count                     packed occupancy per channel (ADDR_WIDTH+1 each)

// One channel: storage, pointers, occupancy and per-channel flags. The bank
// decides acceptance; this lane only applies already-accepted operations.
module vc_fifo_lane #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  clr_n_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic [ADDR_WIDTH-1:0] af_thr_i,
  input  logic [ADDR_WIDTH-1:0] ae_thr_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  af_o,
  output logic                  ae_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [DATA_WIDTH-1:0] peek_o
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] peek_q, peek_d;
  logic                  err_q;

  always_comb begin
    wr_ptr_d = wr_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_i ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_i && !rd_i)      count_d = count_q + 1'b1;
    else if (rd_i && !wr_i) count_d = count_q - 1'b1;
    // Head as of the end of this cycle; a write landing on the new head slot
    // (write into an empty channel) has to bypass the memory.
    if (count_d == '0)                       peek_d = '0;
    else if (wr_i && (wr_ptr_q == rd_ptr_d)) peek_d = din_i;
    else                                     peek_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peek_q   <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peek_q   <= peek_d;
      if (err_i) err_q <= 1'b1;
      if (wr_i)  mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign af_o    = (count_q >= (DEPTH_C - {1'b0, af_thr_i})) && !full_o;
  assign ae_o    = (count_q <= {1'b0, ae_thr_i}) && !empty_o;
  assign err_o   = err_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign peek_o  = peek_q;
endmodule

module vc_fifo_bank #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_VC     = 2,
  parameter int SEL_WIDTH  = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             init,
  input  logic                             wr_enable,
  input  logic [SEL_WIDTH-1:0]             wr_vc,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             rd_enable,
  input  logic [SEL_WIDTH-1:0]             rd_vc,
  input  logic [NUM_VC*ADDR_WIDTH-1:0]     umbral_af,
  input  logic [NUM_VC*ADDR_WIDTH-1:0]     umbral_ae,
  output logic [NUM_VC-1:0]                full,
  output logic [NUM_VC-1:0]                empty,
  output logic [NUM_VC-1:0]                almost_full,
  output logic [NUM_VC-1:0]                almost_empty,
  output logic [NUM_VC-1:0]                error,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             valid_out,
  output logic [NUM_VC*DATA_WIDTH-1:0]     data_peek,
  output logic [NUM_VC*(ADDR_WIDTH+1)-1:0] count
);
  localparam int CW = ADDR_WIDTH + 1;

  logic                             clr_n;
  logic                             bad_sel;
  logic [NUM_VC-1:0]                wr_hit, rd_hit, wr_acc, rd_acc, err_set;
  logic [NUM_VC-1:0]                full_raw, empty_raw, af_raw, ae_raw;
  logic [NUM_VC-1:0][DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0]            dout_d, dout_q;
  logic                             valid_q;

  assign clr_n = reset & init;
  // A select that matches no channel is out of range; reported on bit 0.
  assign bad_sel = (wr_enable && !(|wr_hit)) || (rd_enable && !(|rd_hit));

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign wr_hit[v] = wr_enable && (wr_vc == SEL_WIDTH'(v));
    assign rd_hit[v] = rd_enable && (rd_vc == SEL_WIDTH'(v));
    // A write to a full channel still fits if the same cycle drains one word.
    assign rd_acc[v] = rd_hit[v] && !empty_raw[v];
    assign wr_acc[v] = wr_hit[v] && (!full_raw[v] || rd_acc[v]);
    if (v == 0) begin : g_err0
      assign err_set[v] = (wr_hit[v] && !wr_acc[v]) || (rd_hit[v] && !rd_acc[v]) || bad_sel;
    end else begin : g_errn
      assign err_set[v] = (wr_hit[v] && !wr_acc[v]) || (rd_hit[v] && !rd_acc[v]);
    end

    vc_fifo_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .clk      (clk),
      .clr_n_i  (clr_n),
      .wr_i     (wr_acc[v]),
      .rd_i     (rd_acc[v]),
      .err_i    (err_set[v]),
      .din_i    (data_in),
      .af_thr_i (umbral_af[v*ADDR_WIDTH +: ADDR_WIDTH]),
      .ae_thr_i (umbral_ae[v*ADDR_WIDTH +: ADDR_WIDTH]),
      .count_o  (count[v*CW +: CW]),
      .full_o   (full_raw[v]),
      .empty_o  (empty_raw[v]),
      .af_o     (af_raw[v]),
      .ae_o     (ae_raw[v]),
      .err_o    (error[v]),
      .head_o   (head[v]),
      .peek_o   (data_peek[v*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // At most one channel reads per cycle, so an OR-mux of heads suffices.
  always_comb begin
    dout_d = '0;
    for (int v = 0; v < NUM_VC; v++)
      if (rd_acc[v]) dout_d = dout_d | head[v];
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= |rd_acc;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = valid_q;

  // While reset/init is held the status flags show an empty bank immediately.
  assign full         = clr_n ? full_raw  : '0;
  assign empty        = clr_n ? empty_raw : '1;
  assign almost_full  = clr_n ? af_raw    : '0;
  assign almost_empty = clr_n ? ae_raw    : '0;
endmodule
